// File: rtl/uart_loopback_core.sv
// 8N1 UART transmitter looped back into a 16x-oversampling receiver.
// Define UART_FRAME_ERR_EN to add the frame_err output (stop bit sampled low).
module uart_loopback_core #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  tx_start,
    output logic                  tx_done,
    output logic                  rx_done,
    output logic [DATA_WIDTH-1:0] data_out,
`ifdef UART_FRAME_ERR_EN
    output logic                  frame_err,
`endif
    output logic                  tx_line
);

    localparam int TICK_CYCLES = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int BIT_CYCLES  = TICK_CYCLES * OVERSAMPLE;
    localparam int TICK_W      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int BIT_W       = $clog2(BIT_CYCLES);
    localparam int OS_W        = $clog2(OVERSAMPLE);
    localparam int IDX_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // ---------------- transmitter ----------------
    logic [1:0]            tx_state;
    logic [BIT_W-1:0]      tx_cnt;
    logic [IDX_W-1:0]      tx_idx;
    logic [DATA_WIDTH-1:0] tx_shreg;
    logic                  tx_bit_end;

    assign tx_bit_end = (tx_cnt == BIT_W'(BIT_CYCLES - 1));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shreg <= '0;
            tx_line  <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (tx_state)
                S_IDLE: begin
                    if (tx_start) begin
                        tx_shreg <= data_in;
                        tx_cnt   <= '0;
                        tx_line  <= 1'b0;
                        tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (tx_bit_end) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        tx_line  <= tx_shreg[0];
                        tx_state <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + BIT_W'(1);
                    end
                end
                S_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        if (tx_idx == IDX_W'(DATA_WIDTH - 1)) begin
                            tx_line  <= 1'b1;
                            tx_state <= S_STOP;
                        end else begin
                            // Drive the next bit while shifting so the line changes on the boundary.
                            tx_shreg <= tx_shreg >> 1;
                            tx_line  <= tx_shreg[1];
                            tx_idx   <= tx_idx + IDX_W'(1);
                        end
                    end else begin
                        tx_cnt <= tx_cnt + BIT_W'(1);
                    end
                end
                default: begin
                    if (tx_bit_end) begin
                        tx_cnt   <= '0;
                        tx_done  <= 1'b1;
                        tx_state <= S_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + BIT_W'(1);
                    end
                end
            endcase
        end
    end

    // ---------------- oversampling tick ----------------
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    assign tick = (tick_cnt == TICK_W'(TICK_CYCLES - 1));

    always_ff @(posedge clk or posedge arst) begin
        if (arst)      tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + TICK_W'(1);
    end

    // ---------------- receiver ----------------
    logic [1:0]            rx_state;
    logic [OS_W-1:0]       rx_cnt;
    logic [IDX_W-1:0]      rx_idx;
    logic [DATA_WIDTH-1:0] rx_shreg;
    logic                  rx_sample_pt;

    assign rx_sample_pt = (rx_cnt == OS_W'(OVERSAMPLE - 1));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rx_state  <= S_IDLE;
            rx_cnt    <= '0;
            rx_idx    <= '0;
            rx_shreg  <= '0;
            data_out  <= '0;
            rx_done   <= 1'b0;
`ifdef UART_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
        end else begin
            rx_done <= 1'b0;
`ifdef UART_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
            if (tick) begin
                case (rx_state)
                    S_IDLE: begin
                        if (!tx_line) begin
                            rx_cnt   <= '0;
                            rx_state <= S_START;
                        end
                    end
                    S_START: begin
                        // Half a bit after detection: confirm the start bit, else treat as glitch.
                        if (rx_cnt == OS_W'(OVERSAMPLE / 2 - 2)) begin
                            rx_cnt   <= '0;
                            rx_idx   <= '0;
                            rx_state <= tx_line ? S_IDLE : S_DATA;
                        end else begin
                            rx_cnt <= rx_cnt + OS_W'(1);
                        end
                    end
                    S_DATA: begin
                        if (rx_sample_pt) begin
                            rx_cnt   <= '0;
                            rx_shreg <= {tx_line, rx_shreg[DATA_WIDTH-1:1]};
                            if (rx_idx == IDX_W'(DATA_WIDTH - 1)) rx_state <= S_STOP;
                            else rx_idx <= rx_idx + IDX_W'(1);
                        end else begin
                            rx_cnt <= rx_cnt + OS_W'(1);
                        end
                    end
                    default: begin
                        if (rx_sample_pt) begin
                            rx_cnt    <= '0;
                            data_out  <= rx_shreg;
                            rx_done   <= 1'b1;
`ifdef UART_FRAME_ERR_EN
                            frame_err <= ~tx_line;
`endif
                            rx_state  <= S_IDLE;
                        end else begin
                            rx_cnt <= rx_cnt + OS_W'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_loopback_core.sv
// Scoreboard bench for uart_loopback_core, run at a scaled clock (2 clocks per tick, 32 per bit).
module tb_uart_loopback_core;

    localparam int BAUD  = 9600;
    localparam int OS    = 16;
    localparam int TICKC = 2;
    localparam int CLKF  = BAUD * OS * TICKC;
    localparam int B     = TICKC * OS;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_done, rx_done, tx_line;
    logic [7:0] data_out;
`ifdef UART_FRAME_ERR_EN
    logic       frame_err;
`endif

    uart_loopback_core #(
        .CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_WIDTH(8)
    ) dut (
        .clk(clk), .arst(arst), .data_in(data_in), .tx_start(tx_start),
        .tx_done(tx_done), .rx_done(rx_done), .data_out(data_out),
`ifdef UART_FRAME_ERR_EN
        .frame_err(frame_err),
`endif
        .tx_line(tx_line)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int rx_seen = 0;
    int tx_seen = 0;
    int sent = 0;
    logic [7:0] rx_q[$];
    int         tx_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop expected values whenever the DUT pulses a done output.
    always @(negedge clk) begin
        if (!arst) begin
            if (rx_done) begin
                rx_seen++;
                if (rx_q.size() == 0) chk("rx_unexpected", 32'd1, 32'd0);
                else chk("rx_data", {24'd0, data_out}, {24'd0, rx_q.pop_front()});
`ifdef UART_FRAME_ERR_EN
                chk("frame_err", {31'd0, frame_err}, 32'd0);
`endif
            end
            if (tx_done) begin
                if (tx_q.size() == 0) chk("tx_unexpected", 32'd1, 32'd0);
                else begin
                    chk("tx_done_cycle", cyc, tx_q.pop_front());
                    chk("rx_before_tx", rx_seen, tx_seen + 1);
                end
                tx_seen++;
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input bit push, output int c);
        @(negedge clk);
        data_in  = b;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        c = cyc;
        chk("start_bit_next_cycle", {31'd0, tx_line}, 32'd0);
        if (push) begin
            rx_q.push_back(b);
            tx_q.push_back(c + 10 * B);
            sent++;
        end
        @(negedge clk);
        tx_start = 1'b0;
        data_in  = ~b;
    endtask

    // Check first and last cycle of every bit of the frame on tx_line.
    task automatic check_frame(input int c, input logic [7:0] b);
        logic exp_bit;
        for (int k = 0; k < 10; k++) begin
            exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            wait_until(c + k * B);
            chk($sformatf("bit%0d_first", k), {31'd0, tx_line}, {31'd0, exp_bit});
            wait_until(c + k * B + B - 1);
            chk($sformatf("bit%0d_last", k), {31'd0, tx_line}, {31'd0, exp_bit});
        end
    endtask

    initial begin
        int c;
        int r0;
        logic [7:0] pats[4];
        pats[0] = 8'h01; pats[1] = 8'h80; pats[2] = 8'h00; pats[3] = 8'hFF;

        // Reset
        repeat (5) @(posedge clk);
        @(negedge clk);
        arst = 1'b0;
        #1;
        chk("reset_tx_line", {31'd0, tx_line}, 32'd1);
        chk("reset_data_out", {24'd0, data_out}, 32'd0);
        chk("reset_tx_done", {31'd0, tx_done}, 32'd0);
        chk("reset_rx_done", {31'd0, rx_done}, 32'd0);
        wait_until(cyc + 60 * B);
        chk("idle_no_rx", rx_seen, 0);
        chk("idle_no_tx", tx_seen, 0);
        chk("idle_tx_line", {31'd0, tx_line}, 32'd1);

        // Single byte with full bit-timing check
        send(8'hA5, 1'b1, c);
        check_frame(c, 8'hA5);
        wait_until(c + 12 * B);

        // Bit patterns
        foreach (pats[i]) begin
            send(pats[i], 1'b1, c);
            check_frame(c, pats[i]);
            wait_until(c + 12 * B);
        end

        // Busy ignore: second request mid-frame must be dropped
        r0 = rx_seen;
        send(8'h3C, 1'b1, c);
        wait_until(c + 5 * B);
        @(negedge clk);
        data_in  = 8'hC3;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        wait_until(c + 12 * B);
        chk("busy_one_rx", rx_seen, r0 + 1);
        chk("busy_tx_line_idle", {31'd0, tx_line}, 32'd1);

        // Random regression
        for (int i = 0; i < 100; i++) begin
            send(8'($urandom_range(0, 255)), 1'b1, c);
            wait_until(c + 12 * B);
        end

        // Reset mid-frame
        r0 = rx_seen;
        send(8'h96, 1'b0, c);
        wait_until(c + 4 * B);
        @(negedge clk);
        arst = 1'b1;
        #1;
        chk("midreset_tx_line", {31'd0, tx_line}, 32'd1);
        repeat (3) @(negedge clk);
        arst = 1'b0;
        wait_until(cyc + 12 * B);
        chk("midreset_no_rx", rx_seen, r0);
        chk("midreset_data_out", {24'd0, data_out}, 32'd0);
        send(8'h5A, 1'b1, c);
        check_frame(c, 8'h5A);
        wait_until(c + 12 * B);

        chk("rx_q_drained", rx_q.size(), 0);
        chk("tx_q_drained", tx_q.size(), 0);
        chk("rx_count", rx_seen, sent);
        chk("tx_count", tx_seen, sent);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
